// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_pkg;

    localparam int unsigned DEF_ADDR_W  = 14;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_DEPTH   = 2;
    localparam int unsigned DEF_PC_STEP = 4;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    // One prefetched word together with the PC it was fetched from.
    // Instances with non-default widths build an equivalent local struct
    // and hand it to the FIFO as a type parameter.
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Width of an occupancy counter that must also represent "full".
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, wrap-around pointers, single-cycle flush.
// Head entry is presented combinationally from the read pointer.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned CW      = occ_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n,   // active-high, asynchronous
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t [DEPTH-1:0] mem;
    logic   [AW-1:0]    wr_ptr;
    logic   [AW-1:0]    rd_ptr;
    logic   [CW-1:0]    cnt_q;

    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    // Storage is cleared on reset so the head outputs read as zero then;
    // after a flush the stale head is left in place (don't-care while empty).
    assign rdata = mem[rd_ptr];

    // Pointer and count update; flush discards everything including a
    // same-cycle push or pop.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            mem <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Decode can only pop a valid head.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_n)
        (pop && !flush) |-> !empty);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch unit: drives a 1-cycle-latency ROM, tags each returned
// word with its PC, buffers pairs in a prefetch FIFO and hands the head to
// decode over valid/ready. A redirect flushes all speculative state.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        INSTR_W  = DEF_INSTR_W,
    parameter int unsigned        DEPTH    = DEF_DEPTH,
    parameter int unsigned        PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_n,           // active-high, asynchronous
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_addr_i,
    output logic                     rom_en_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [INSTR_W-1:0]       rom_data_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [INSTR_W-1:0]       instr_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic [occ_w(DEPTH)-1:0]  occupancy_o
);

    localparam int unsigned CW = occ_w(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ifetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag_pc;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              push;
    logic [CW:0]       demand;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    entry_t            head;
    entry_t            resp;

    assign pop = instr_valid_o & instr_ready_i;

    // Slots that will be taken after this edge: queued + returning - leaving.
    // Issuing only while this stays below DEPTH makes overflow impossible,
    // and lets a pop free a slot for an issue in the same cycle.
    assign demand = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    // Issue decision; held off while reset is asserted so the ROM sees no
    // request during reset.
    always_comb begin
        issue = 1'b0;
        if (!rst_n && !redirect_i && (demand < (CW+1)'(DEPTH)))
            issue = 1'b1;
    end

    assign rom_en_o   = issue;
    assign rom_addr_o = fetch_pc;

    // A response returning in a redirect cycle belongs to the old path.
    assign push       = inflight & !redirect_i;
    assign resp.instr = rom_data_i;
    assign resp.pc    = tag_pc;

    // Fetch PC: redirect wins over sequential advance; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_addr_i;
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    // Inflight flag and PC tag for the request whose data returns next cycle.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            inflight <= 1'b0;
            tag_pc   <= '0;
        end else begin
            inflight <= issue;
            if (issue) tag_pc <= fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CW      (CW)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (resp),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign instr_valid_o = !empty;
    assign instr_o       = head.instr;
    assign addr_o        = head.pc;
    assign occupancy_o   = count;

    // The issue rule keeps a slot free for every outstanding response.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_n)
        push |-> !full);

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized
// run against a PC-stream reference model.
module tb_ifetch_queue;

    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk_i = 1'b0;
    logic               rst_n = 1'b1;
    logic               redirect_i = 1'b0;
    logic [ADDR_W-1:0]  redirect_addr_i = '0;
    logic               rom_en_o;
    logic [ADDR_W-1:0]  rom_addr_o;
    logic [INSTR_W-1:0] rom_data_i = '0;
    logic               instr_valid_o;
    logic               instr_ready_i = 1'b0;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  addr_o;
    logic [CW-1:0]      occupancy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // ROM model: word index = byte address / 4, data returned one cycle later.
    always @(posedge clk_i) if (rom_en_o) rom_data_i <= INSTR_W'(rom_addr_o >> 2);

    ifetch_queue #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC('0)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .addr_o(addr_o), .occupancy_o(occupancy_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        rst_n = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b0;
        tick(); tick(); settle();
        checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en_o); end
        checks++; if (rom_addr_o !== 14'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_o); end
        checks++; if (addr_o !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] e;
        do_reset(); instr_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            e = ADDR_W'(4 * c);
            checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== e) begin errors++; $display("FAIL stream_issue c%0d: got en=%b addr=%h want en=1 addr=%h", c, rom_en_o, rom_addr_o, e); end
            if (c >= 2) begin
                e = ADDR_W'(4 * (c - 2));
                checks++; if (instr_valid_o !== 1'b1 || addr_o !== e || instr_o !== INSTR_W'(c - 2)) begin errors++; $display("FAIL stream_deliver c%0d: got v=%b addr=%h instr=%h want v=1 addr=%h instr=%h", c, instr_valid_o, addr_o, instr_o, e, c - 2); end
            end else begin
                checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stream_latency c%0d: got valid=%b want 0", c, instr_valid_o); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int issues = 0;
        do_reset(); instr_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (rom_en_o) issues++;
            tick();
        end
        settle();
        checks++; if (issues != DEPTH) begin errors++; $display("FAIL stall_issues: got %0d want %0d", issues, DEPTH); end
        checks++; if (occupancy_o !== CW'(DEPTH)) begin errors++; $display("FAIL stall_occ: got %0d want %0d", occupancy_o, DEPTH); end
        checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL stall_rom_en: got %b want 0", rom_en_o); end
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h0 || instr_o !== 32'h0) begin errors++; $display("FAIL stall_head: got v=%b addr=%h instr=%h want v=1 addr=0 instr=0", instr_valid_o, addr_o, instr_o); end
        instr_ready_i = 1'b1;
        for (int r = 0; r < 6; r++) begin
            settle();
            checks++; if (instr_valid_o !== 1'b1 || addr_o !== ADDR_W'(4 * r) || instr_o !== INSTR_W'(r)) begin errors++; $display("FAIL stall_resume_pop r%0d: got v=%b addr=%h instr=%h want addr=%h", r, instr_valid_o, addr_o, instr_o, 4 * r); end
            checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== ADDR_W'(8 + 4 * r)) begin errors++; $display("FAIL stall_resume_issue r%0d: got en=%b addr=%h want en=1 addr=%h", r, rom_en_o, rom_addr_o, 8 + 4 * r); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset(); instr_ready_i = 1'b0;
        tick(); tick();
        redirect_i = 1'b1; redirect_addr_i = 14'h100;
        settle();
        checks++; if (occupancy_o !== CW'(1)) begin errors++; $display("FAIL redir_pre_occ: got %0d want 1", occupancy_o); end
        checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b want 0", rom_en_o); end
        tick();
        redirect_i = 1'b0; instr_ready_i = 1'b1;
        settle();
        checks++; if (occupancy_o !== '0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_flush: got occ=%0d v=%b want occ=0 v=0", occupancy_o, instr_valid_o); end
        checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== 14'h100) begin errors++; $display("FAIL redir_issue: got en=%b addr=%h want en=1 addr=100", rom_en_o, rom_addr_o); end
        tick(); settle();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_n2_valid: got %b want 0", instr_valid_o); end
        tick(); settle();
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h100 || instr_o !== 32'h40) begin errors++; $display("FAIL redir_n3: got v=%b addr=%h instr=%h want v=1 addr=100 instr=40", instr_valid_o, addr_o, instr_o); end
        tick(); settle();
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h104 || instr_o !== 32'h41) begin errors++; $display("FAIL redir_n4: got v=%b addr=%h instr=%h want v=1 addr=104 instr=41", instr_valid_o, addr_o, instr_o); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset(); instr_ready_i = 1'b1;
        tick(); tick();
        redirect_i = 1'b1; redirect_addr_i = 14'h3FFC;
        tick();
        redirect_i = 1'b0;
        tick(); tick(); settle();
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h3FFC || instr_o !== 32'hFFF) begin errors++; $display("FAIL wrap_top: got v=%b addr=%h instr=%h want v=1 addr=3ffc instr=fff", instr_valid_o, addr_o, instr_o); end
        tick(); settle();
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h0000 || instr_o !== 32'h0) begin errors++; $display("FAIL wrap_zero: got v=%b addr=%h instr=%h want v=1 addr=0 instr=0", instr_valid_o, addr_o, instr_o); end
        tick(); settle();
        checks++; if (instr_valid_o !== 1'b1 || addr_o !== 14'h0004 || instr_o !== 32'h1) begin errors++; $display("FAIL wrap_next: got v=%b addr=%h instr=%h want v=1 addr=4 instr=1", instr_valid_o, addr_o, instr_o); end
        tick();
    endtask

    task automatic test_async_reset();
        bit found = 0;
        do_reset(); instr_ready_i = 1'b0;
        tick(); tick(); settle();
        checks++; if (occupancy_o !== CW'(1)) begin errors++; $display("FAIL areset_pre_occ: got %0d want 1", occupancy_o); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (rom_en_o !== 1'b0 || rom_addr_o !== 14'h0) begin errors++; $display("FAIL areset_rom: got en=%b addr=%h want en=0 addr=0", rom_en_o, rom_addr_o); end
        checks++; if (instr_valid_o !== 1'b0 || occupancy_o !== '0) begin errors++; $display("FAIL areset_queue: got v=%b occ=%0d want v=0 occ=0", instr_valid_o, occupancy_o); end
        checks++; if (instr_o !== 32'h0 || addr_o !== 14'h0) begin errors++; $display("FAIL areset_head: got instr=%h addr=%h want 0/0", instr_o, addr_o); end
        tick(); tick();
        rst_n = 1'b0; instr_ready_i = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            settle();
            if (instr_valid_o) begin
                found = 1;
                checks++; if (addr_o !== 14'h0 || instr_o !== 32'h0) begin errors++; $display("FAIL areset_first: got addr=%h instr=%h want 0/0", addr_o, instr_o); end
            end
            tick();
        end
        if (!found) begin checks++; errors++; $display("FAIL areset_timeout: got no delivery want one within 10 cycles"); end
    endtask

    task automatic test_double_redirect();
        do_reset(); instr_ready_i = 1'b1;
        repeat (4) tick();
        redirect_i = 1'b1; redirect_addr_i = 14'h40;
        tick();
        redirect_addr_i = 14'h80;
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k < 2) begin
                checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL dbl_gap k%0d: got v=%b addr=%h want v=0", k, instr_valid_o, addr_o); end
            end else begin
                checks++; if (instr_valid_o !== 1'b1 || addr_o !== ADDR_W'(14'h80 + 4 * (k - 2))) begin errors++; $display("FAIL dbl_stream k%0d: got v=%b addr=%h want v=1 addr=%h", k, instr_valid_o, addr_o, 14'h80 + 4 * (k - 2)); end
            end
            tick();
        end
    endtask

    // Reference: the delivered PCs form a sequential stream restarting at
    // each redirect target; issued PCs follow the same rule.
    task automatic test_random();
        logic [ADDR_W-1:0] exp_pc, exp_iss, tgt;
        int n_deliv = 0;
        do_reset();
        exp_pc = '0; exp_iss = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready_i = ($urandom_range(0, 99) < 70);
            redirect_i    = ($urandom_range(0, 99) < 4);
            tgt = ADDR_W'($urandom) & ~ADDR_W'(3);
            if ($urandom_range(0, 3) == 0) tgt = ADDR_W'(14'h3FF4 + 4 * $urandom_range(0, 2));
            redirect_addr_i = tgt;
            settle();
            checks++; if ((occupancy_o != 0) !== instr_valid_o || occupancy_o > CW'(DEPTH)) begin errors++; $display("FAIL rnd_occ cyc%0d: got occ=%0d v=%b want consistent, <=%0d", cyc, occupancy_o, instr_valid_o, DEPTH); end
            if (rom_en_o) begin
                checks++; if (redirect_i || rom_addr_o !== exp_iss) begin errors++; $display("FAIL rnd_issue cyc%0d: got addr=%h redir=%b want addr=%h no redirect", cyc, rom_addr_o, redirect_i, exp_iss); end
                exp_iss = exp_iss + ADDR_W'(4);
            end
            if (instr_valid_o && instr_ready_i) begin
                checks++; if (addr_o !== exp_pc || instr_o !== INSTR_W'(exp_pc >> 2)) begin errors++; $display("FAIL rnd_deliver cyc%0d: got addr=%h instr=%h want addr=%h instr=%h", cyc, addr_o, instr_o, exp_pc, INSTR_W'(exp_pc >> 2)); end
                exp_pc = exp_pc + ADDR_W'(4);
                n_deliv++;
            end
            if (redirect_i) begin
                exp_pc = tgt; exp_iss = tgt;
            end
            tick();
        end
        redirect_i = 1'b0;
        checks++; if (n_deliv < 500) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 500", n_deliv); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_double_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
